aes_inv_cipher_core: RTL

//  Iterative AES-128 inverse cipher: ciphertext + cipher key in, plaintext out, one round per clock.

---
 rtl/aes_inv_cipher_core.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES-128 inverse cipher, one round per clock.
//   A forward key expansion fills an 11-entry round-key store (one key per
//   clock). Ten inverse rounds then run, also one per clock. When KEY_CACHE
//   is set and the key matches the last fully expanded key, expansion is
//   skipped.
// Ports:
//   AES_clk            rising-edge clock
//   AES_rst            synchronous active-high reset
//   AES_dec_en         start request, accepted only while AES_busy = 0
//   AES_data_in        ciphertext, byte 0 = bits [127:120]
//   AES_key_in         cipher key, same byte order
//   AES_busy           high from the accepting edge until the completing edge
//   AES_data_out       plaintext, held until the next completion
//   AES_data_out_valid one-cycle pulse when AES_data_out updates

// Combinational S-box (INV=0) or inverse S-box (INV=1).
// Built from GF(2^8) inversion and the affine map rather than a 256-entry table.
module aes_sbox #(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  always_comb begin
    if (INV) begin
      out_byte = gf_inv(rotl(in_byte, 1) ^ rotl(in_byte, 3) ^ rotl(in_byte, 6) ^ 8'h05);
    end else begin
      out_byte = gf_inv(in_byte);
      out_byte = out_byte ^ rotl(out_byte, 1) ^ rotl(out_byte, 2)
               ^ rotl(out_byte, 3) ^ rotl(out_byte, 4) ^ 8'h63;
    end
  end
endmodule

module aes_inv_cipher_core #(
  parameter int KEY_CACHE = 1
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_dec_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic         AES_busy,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_FINAL  = 2'd3;
  localparam bit CACHE_ON = (KEY_CACHE != 0);

  logic [1:0]   fsm_reg;
  logic [3:0]   rnd_reg;
  logic [127:0] state_reg;
  logic [127:0] data_out_reg;
  logic         busy_reg;
  logic         valid_reg;
  logic         cache_valid_reg;
  logic [127:0] rk_reg [0:10];

  // rk_reg[0] is the raw cipher key, so it doubles as the cached key.
  logic key_hit;
  assign key_hit = CACHE_ON && cache_valid_reg && (AES_key_in == rk_reg[0]);

  // ---------------- forward key expansion (one round key per clock)
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;
  logic [7:0]   rcon;

  assign rk_prev  = rk_reg[rnd_reg - 4'd1];
  assign rot_word = {rk_prev[23:0], rk_prev[31:24]};

  always_comb begin
    case (rnd_reg)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox #(.INV(1'b0)) u_sbox (
      .in_byte  (rot_word[31-8*gi -: 8]),
      .out_byte (sub_word[31-8*gi -: 8])
    );
  end

  assign temp_word        = sub_word ^ {rcon, 24'h000000};
  assign rk_next[127:96]  = rk_prev[127:96] ^ temp_word;
  assign rk_next[95:64]   = rk_prev[95:64]  ^ rk_next[127:96];
  assign rk_next[63:32]   = rk_prev[63:32]  ^ rk_next[95:64];
  assign rk_next[31:0]    = rk_prev[31:0]   ^ rk_next[63:32];

  // ---------------- inverse round datapath
  logic [127:0] shifted;
  logic [127:0] inv_sub;
  logic [127:0] added;
  logic [127:0] mixed;

  // Byte r+4c of the result comes from row r, column (c-r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign shifted[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
    aes_sbox #(.INV(1'b1)) u_inv_sbox (
      .in_byte  (shifted[127-8*gi -: 8]),
      .out_byte (inv_sub[127-8*gi -: 8])
    );
  end

  // In ROUND rnd_reg runs 9..1; in FINAL it has reached 0, selecting rk[0].
  assign added = inv_sub ^ rk_reg[rnd_reg];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul09(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mul0b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] mul0d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] mul0e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_mixcol
    logic [7:0] a0, a1, a2, a3;
    assign a0 = added[127-32*gi -: 8];
    assign a1 = added[119-32*gi -: 8];
    assign a2 = added[111-32*gi -: 8];
    assign a3 = added[103-32*gi -: 8];
    assign mixed[127-32*gi -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    assign mixed[119-32*gi -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    assign mixed[111-32*gi -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    assign mixed[103-32*gi -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
  end

  // ---------------- round-key store (deliberately not reset; the cache flag is)
  always_ff @(posedge AES_clk) begin
    if (!AES_rst) begin
      if (fsm_reg == S_IDLE && AES_dec_en && !key_hit) begin
        rk_reg[0] <= AES_key_in;
      end else if (fsm_reg == S_KEYEXP) begin
        rk_reg[rnd_reg] <= rk_next;
      end
    end
  end

  // ---------------- control FSM
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fsm_reg         <= S_IDLE;
      rnd_reg         <= 4'd0;
      state_reg       <= '0;
      data_out_reg    <= '0;
      busy_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      cache_valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (fsm_reg)
        S_IDLE: begin
          if (AES_dec_en) begin
            busy_reg <= 1'b1;
            if (key_hit) begin
              state_reg <= AES_data_in ^ rk_reg[10];
              rnd_reg   <= 4'd9;
              fsm_reg   <= S_ROUND;
            end else begin
              // Ciphertext waits in state_reg until rk[10] is known.
              state_reg       <= AES_data_in;
              cache_valid_reg <= 1'b0;
              rnd_reg         <= 4'd1;
              fsm_reg         <= S_KEYEXP;
            end
          end
        end
        S_KEYEXP: begin
          if (rnd_reg == 4'd10) begin
            state_reg       <= state_reg ^ rk_next;
            cache_valid_reg <= 1'b1;
            rnd_reg         <= 4'd9;
            fsm_reg         <= S_ROUND;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        S_ROUND: begin
          state_reg <= mixed;
          rnd_reg   <= rnd_reg - 4'd1;
          if (rnd_reg == 4'd1) fsm_reg <= S_FINAL;
        end
        default: begin
          data_out_reg <= added;
          valid_reg    <= 1'b1;
          busy_reg     <= 1'b0;
          fsm_reg      <= S_IDLE;
        end
      endcase
    end
  end

  assign AES_busy           = busy_reg;
  assign AES_data_out       = data_out_reg;
  assign AES_data_out_valid = valid_reg;
endmodule
